// File: rtl/coax_rx.sv
// coax_rx: 3270 coax line receiver.
// Recovers mid-bit timing from oversampled rx and deframes 10-bit words.
module coax_rx #(
    parameter int CLOCKS_PER_BIT   = 8,
    parameter int MIN_QUIESCE_BITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       active,
    output logic [9:0] data,
    output logic       data_strobe,
    output logic       parity_error,
    output logic       error
);

    localparam int C  = CLOCKS_PER_BIT;
    localparam int Q  = C / 4;
    localparam int CW = $clog2(3 * C + 1);
    localparam int QW = $clog2(MIN_QUIESCE_BITS + 1);

    localparam logic [CW-1:0] MID_LO  = CW'(C - Q);
    localparam logic [CW-1:0] MID_HI  = CW'(C + Q);
    localparam logic [CW-1:0] CV_LO   = CW'(2 * C - Q);
    localparam logic [CW-1:0] CV_HI   = CW'(2 * C + Q);
    localparam logic [CW-1:0] CNT_MAX = CW'(3 * C);
    localparam logic [QW-1:0] Q_FULL  = QW'(MIN_QUIESCE_BITS);

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        CV_WAIT,
        SYNC_WAIT,
        DATA,
        PARITY,
        NEXT
    } state_t;

    state_t        state, state_n;
    logic          rx_s1, rx_s2, rx_d;
    logic [CW-1:0] cnt, cnt_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [9:0]    shreg, shreg_n;
    logic          par, par_n;
    logic          active_n, strobe_n, perr_n, err_n;
    logic [9:0]    data_n;

    logic rx_edge, rx_rise, mid, in_cv, to_bit, to_cv;

    assign rx_edge = rx_s2 ^ rx_d;
    assign rx_rise = rx_edge & rx_s2;
    assign mid     = rx_edge && cnt >= MID_LO && cnt <= MID_HI;
    assign in_cv   = cnt >= CV_LO && cnt <= CV_HI;
    // Timeouts fire one cycle early so the registered outputs
    // land in the cycle cnt first passes the window.
    assign to_bit  = !rx_edge && cnt >= MID_HI;
    assign to_cv   = !rx_rise && cnt >= CV_HI;

    // Two-flop synchronizer plus one-flop edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b0;
            rx_s2 <= 1'b0;
            rx_d  <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // State, timing counter, shift register and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            qcnt         <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            active       <= 1'b0;
            data         <= '0;
            data_strobe  <= 1'b0;
            parity_error <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            qcnt         <= qcnt_n;
            bitcnt       <= bitcnt_n;
            shreg        <= shreg_n;
            par          <= par_n;
            active       <= active_n;
            data         <= data_n;
            data_strobe  <= strobe_n;
            parity_error <= perr_n;
            error        <= err_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        qcnt_n   = qcnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        active_n = active;
        data_n   = data;
        perr_n   = parity_error;
        strobe_n = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_edge) begin
                    cnt_n   = '0;
                    qcnt_n  = '0;
                    state_n = QUIESCE;
                end
            end
            QUIESCE: begin
                if (mid) begin
                    cnt_n = '0;
                    if (!rx_s2)
                        qcnt_n = '0;
                    else if (qcnt != Q_FULL)
                        qcnt_n = qcnt + QW'(1);
                end else if (to_bit) begin
                    if (!rx_s2 && qcnt == Q_FULL)
                        state_n = CV_WAIT;
                    else
                        state_n = IDLE;
                end
            end
            CV_WAIT: begin
                if (rx_rise && in_cv) begin
                    state_n  = SYNC_WAIT;
                    cnt_n    = '0;
                    active_n = 1'b1;
                end else if (rx_rise || to_cv) begin
                    state_n = IDLE;
                end
            end
            SYNC_WAIT: begin
                if (rx_rise && in_cv) begin
                    state_n  = DATA;
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    par_n    = 1'b1;
                end else if (rx_rise || to_cv) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                    err_n    = 1'b1;
                end
            end
            DATA: begin
                if (mid) begin
                    cnt_n   = '0;
                    shreg_n = {shreg[8:0], rx_s2};
                    par_n   = par ^ rx_s2;
                    if (bitcnt == 4'd9)
                        state_n = PARITY;
                    else
                        bitcnt_n = bitcnt + 4'd1;
                end else if (to_bit) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                    err_n    = 1'b1;
                end
            end
            PARITY: begin
                if (mid) begin
                    cnt_n    = '0;
                    data_n   = shreg;
                    strobe_n = 1'b1;
                    perr_n   = par ^ rx_s2;
                    state_n  = NEXT;
                end else if (to_bit) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                    err_n    = 1'b1;
                end
            end
            NEXT: begin
                if (mid) begin
                    cnt_n = '0;
                    if (rx_s2) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                        par_n    = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        active_n = 1'b0;
                    end
                end else if (to_bit) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                    err_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
